// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share a single FIFO write port.
// Each grant costs one idle arbitration cycle and lasts for at most MAX_BURST words.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [15:0]               xfer_count
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [2:0]        owner;
    logic [2:0]        last_owner;
    logic [3:0]        burst_cnt;
    logic [3:0]        burst_next;
    logic [2:0]        pick;
    logic              pick_found;
    logic [3:0]        cand;
    logic              xfer;
    logic [7:0]        valid_ext;
    logic [DATA_W-1:0] data_arr [8];

    // Widen the requester lanes to eight so a 3-bit index is always in range.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        if (i < NUM_REQ) begin : g_used
            assign valid_ext[i] = req_valid[i];
            assign data_arr[i]  = req_data[i*DATA_W +: DATA_W];
        end else begin : g_unused
            assign valid_ext[i] = 1'b0;
            assign data_arr[i]  = '0;
        end
    end

    // Rotating search that starts just after the previous owner.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_owner} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!pick_found && valid_ext[cand[2:0]]) begin
                pick       = cand[2:0];
                pick_found = 1'b1;
            end
        end
    end

    assign xfer       = (state == GRANT) && valid_ext[owner] && !fifo_full;
    assign burst_next = burst_cnt + 4'd1;

    // The write path is combinational so an accepted word reaches the FIFO in the same cycle.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = xfer;
        fifo_wr_data = xfer ? data_arr[owner] : '0;
        if (state == GRANT && !fifo_full) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= 3'(NUM_REQ - 1);
            burst_cnt  <= '0;
            xfer_count <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        owner     <= pick;
                        burst_cnt <= '0;
                        grant_id  <= pick;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    // A stalled FIFO neither moves data nor uses up the burst allowance.
                    if (xfer) begin
                        xfer_count <= xfer_count + 16'd1;
                        burst_cnt  <= burst_next;
                        if (burst_next == 4'(MAX_BURST)) begin
                            state      <= IDLE;
                            last_owner <= owner;
                            grant_id   <= '0;
                            busy       <= 1'b0;
                        end
                    end else if (!valid_ext[owner]) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        grant_id   <= '0;
                        busy       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural reference model.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full = 1'b0;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [15:0]               xfer_count;

    int errors = 0;
    int checks = 0;

    fifo_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .xfer_count  (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic full);
        req_valid = v;
        fifo_full = full;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = $urandom();
        end
    endtask

    task automatic sampleCycle;
        @(negedge clk);
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [NUM_REQ-1:0] v);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(v, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rrPick(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Reference model: who owns the port, how many words it has moved, who owned it last.
    int          m_owner = 0;
    int          m_last  = NUM_REQ - 1;
    int          m_burst = 0;
    bit          m_busy  = 1'b0;
    logic [15:0] m_count = '0;

    always @(negedge clk or negedge rst_n) begin : model_step
        logic [NUM_REQ-1:0] e_ready;
        logic               e_wr;
        logic [DATA_W-1:0]  e_data;
        int                 p;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = NUM_REQ - 1;
            m_burst = 0;
            m_count = '0;
        end else begin
            e_ready = '0;
            if (m_busy && !fifo_full) e_ready[m_owner] = 1'b1;
            e_wr   = m_busy && req_valid[m_owner] && !fifo_full;
            e_data = e_wr ? req_data[m_owner*DATA_W +: DATA_W] : '0;
            checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
            checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
            checkOutput("fifo_wr_data", 32'(fifo_wr_data), 32'(e_data));
            checkOutput("grant_id", 32'(grant_id), 32'(m_busy ? m_owner : 0));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("xfer_count", 32'(xfer_count), 32'(m_count));
            if (!m_busy) begin
                p = rrPick(m_last, req_valid);
                if (p >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = p;
                    m_burst = 0;
                end
            end else if (e_wr) begin
                m_count = m_count + 16'd1;
                m_burst++;
                if (m_burst == MAX_BURST) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end else if (!req_valid[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          sent;
        int          writes;
        int          idle_cnt;
        int          seen;
        int          cyc;
        bit          prev_busy;
        logic [9:0]  pattern;
        logic [NUM_REQ-1:0] v;
        int          grants[$];
        int          writes_per[$];
        int          exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};

        // Power-on reset values
        rst_n = 1'b0;
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        checkOutput("rst_wr_data", 32'(fifo_wr_data), 32'h0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_xfer_count", 32'(xfer_count), 32'h0);

        // Single requester, six words: bubble, 4 writes, bubble, 2 writes
        doReset(4'b0001);
        sent    = 0;
        pattern = '0;
        for (int c = 0; c < 10; c++) begin
            sampleCycle;
            pattern[c] = fifo_wr_en;
            if (fifo_wr_en) sent++;
            nextCycle;
            applyStimulus((sent >= 6) ? 4'b0000 : 4'b0001, 1'b0);
        end
        checkOutput("single_pattern", 32'(pattern), 32'(10'b0011011110));
        sampleCycle;
        checkOutput("single_count", 32'(xfer_count), 32'd6);
        nextCycle;

        // All four requesting: grants rotate 0,1,2,3,0 with a bubble between each
        doReset(4'b1111);
        prev_busy = 1'b0;
        idle_cnt  = 0;
        for (int c = 0; c < 25; c++) begin
            sampleCycle;
            if (busy && !prev_busy) begin
                grants.push_back(int'(grant_id));
                writes_per.push_back(0);
            end
            if (fifo_wr_en && writes_per.size() > 0) writes_per[writes_per.size()-1]++;
            if (!busy) idle_cnt++;
            prev_busy = busy;
            nextCycle;
            applyStimulus(4'b1111, 1'b0);
        end
        checkOutput("rr_num_grants", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            checkOutput($sformatf("rr_order_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end
        for (int i = 0; i < 4 && i < writes_per.size(); i++) begin
            checkOutput($sformatf("rr_writes_%0d", i), 32'(writes_per[i]), 32'd4);
        end
        checkOutput("rr_idle_cycles", 32'(idle_cnt), 32'd5);

        // Back-pressure mid-burst on owner 2 for three cycles
        doReset(4'b0100);
        writes = 0;
        for (int c = 0; c < 9; c++) begin
            applyStimulus(4'b0100, (c >= 3 && c <= 5));
            sampleCycle;
            if (c >= 3 && c <= 5) begin
                checkOutput("stall_ready", 32'(req_ready), 32'h0);
                checkOutput("stall_wr_en", 32'(fifo_wr_en), 32'h0);
                checkOutput("stall_grant", 32'(grant_id), 32'd2);
            end
            if (fifo_wr_en) writes++;
            if (c == 8) checkOutput("stall_release", 32'(busy), 32'h0);
            nextCycle;
        end
        checkOutput("stall_total_writes", 32'(writes), 32'd4);

        // Owner 1 drops valid after two words while requester 3 waits
        doReset(4'b1010);
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus((c >= 3) ? 4'b1000 : 4'b1010, 1'b0);
            sampleCycle;
            if (c <= 3 && fifo_wr_en) writes++;
            if (c == 1) checkOutput("early_owner1", 32'(grant_id), 32'd1);
            if (c == 4) checkOutput("early_idle", 32'(busy), 32'h0);
            if (c == 5) checkOutput("early_owner3", 32'(grant_id), 32'd3);
            nextCycle;
        end
        checkOutput("early_writes", 32'(writes), 32'd2);

        // Asynchronous reset in the middle of a burst
        doReset(4'b1111);
        sampleCycle;
        nextCycle;
        applyStimulus(4'b1111, 1'b0);
        sampleCycle;
        nextCycle;
        applyStimulus(4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_req_ready", 32'(req_ready), 32'h0);
        checkOutput("async_wr_en", 32'(fifo_wr_en), 32'h0);
        checkOutput("async_wr_data", 32'(fifo_wr_data), 32'h0);
        checkOutput("async_grant_id", 32'(grant_id), 32'h0);
        checkOutput("async_busy", 32'(busy), 32'h0);
        checkOutput("async_xfer_count", 32'(xfer_count), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sampleCycle;
        nextCycle;
        applyStimulus(4'b1111, 1'b0);
        sampleCycle;
        checkOutput("async_first_grant", 32'(grant_id), 32'd0);
        checkOutput("async_first_busy", 32'(busy), 32'd1);
        nextCycle;

        // Randomized traffic with back-pressure and one asynchronous reset
        doReset(4'b0000);
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) v[i] = ($urandom_range(0, 3) != 0);
            applyStimulus(v, ($urandom_range(0, 4) == 0));
            if (n == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("rand_reset_busy", 32'(busy), 32'h0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                nextCycle;
            end
        end

        // Counter wrap: 65535 transfers, then one more
        doReset(4'b0001);
        seen = 0;
        cyc  = 0;
        sampleCycle;
        while (seen < 65535 && cyc < 90000) begin
            if (fifo_wr_en) seen++;
            nextCycle;
            applyStimulus(4'b0001, 1'b0);
            sampleCycle;
            cyc++;
        end
        checkOutput("wrap_transfers", 32'(seen), 32'd65535);
        checkOutput("wrap_count_ffff", 32'(xfer_count), 32'h0000ffff);
        cyc = 0;
        while (!fifo_wr_en && cyc < 8) begin
            nextCycle;
            applyStimulus(4'b0001, 1'b0);
            sampleCycle;
            cyc++;
        end
        nextCycle;
        applyStimulus(4'b0000, 1'b0);
        sampleCycle;
        checkOutput("wrap_count_zero", 32'(xfer_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
